// File: rtl/frame_buf_ring_sel.sv
// Frame-buffer ring selector: hands out write/read buffer indices for NUM_BUFS
// SRAM frame buffers arranged in a ring, in FIFO or latest-frame mode.
// Optional statistics counters are built when FRAME_BUF_STATS_EN is defined.
module frame_buf_ring_sel #(
    parameter int unsigned NUM_BUFS    = 3,
    parameter bit          LATEST_ONLY = 1'b0,
    parameter int unsigned IDX_W       = $clog2(NUM_BUFS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_done,
    input  logic             rd_swap,
    output logic [IDX_W-1:0] wr_idx,
    output logic [IDX_W-1:0] rd_idx,
    output logic             wr_ready,
    output logic [IDX_W-1:0] ready_cnt,
    output logic             rd_repeat,
    output logic             wr_err
`ifdef FRAME_BUF_STATS_EN
    ,
    output logic [15:0]      repeat_total,
    output logic [15:0]      skip_total,
    output logic [15:0]      err_total
`endif
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BUFS - 1);

    // Explicit compare-and-wrap so non-power-of-2 ring sizes work.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (v == LAST) ? '0 : v + IDX_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] wrap_dec(input logic [IDX_W-1:0] v);
        return (v == '0) ? LAST : v - IDX_W'(1);
    endfunction

    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] ready_cnt_q, ready_cnt_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_repeat_q, rd_repeat_d;
    logic             wr_err_q, wr_err_d;
    logic             wr_accept;
    logic             rd_take;

    // Next-state: swap decisions use the pre-update ready_cnt, so a frame
    // finishing this cycle only becomes visible at the following swap.
    always_comb begin
        wr_accept   = wr_done & wr_ready_q;
        rd_take     = rd_swap & (ready_cnt_q != '0);
        rd_idx_d    = rd_idx_q;
        wr_idx_d    = wr_idx_q;
        ready_cnt_d = ready_cnt_q;

        if (wr_accept) begin
            wr_idx_d = wrap_inc(wr_idx_q);
        end

        if (rd_take) begin
            if (LATEST_ONLY) begin
                // Newest completed frame sits just behind the pre-update writer.
                rd_idx_d    = wrap_dec(wr_idx_q);
                ready_cnt_d = wr_accept ? IDX_W'(1) : '0;
            end else begin
                rd_idx_d    = wrap_inc(rd_idx_q);
                ready_cnt_d = wr_accept ? ready_cnt_q : ready_cnt_q - IDX_W'(1);
            end
        end else if (wr_accept) begin
            ready_cnt_d = ready_cnt_q + IDX_W'(1);
        end

        wr_ready_d  = (ready_cnt_d != LAST);
        rd_repeat_d = rd_swap & (ready_cnt_q == '0);
        wr_err_d    = wr_done & ~wr_ready_q;
    end

    // Core state registers; reset discards all queued frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx_q    <= '0;
            wr_idx_q    <= IDX_W'(1);
            ready_cnt_q <= '0;
            wr_ready_q  <= 1'b1;
            rd_repeat_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            ready_cnt_q <= ready_cnt_d;
            wr_ready_q  <= wr_ready_d;
            rd_repeat_q <= rd_repeat_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign rd_idx    = rd_idx_q;
    assign wr_idx    = wr_idx_q;
    assign ready_cnt = ready_cnt_q;
    assign wr_ready  = wr_ready_q;
    assign rd_repeat = rd_repeat_q;
    assign wr_err    = wr_err_q;

`ifdef FRAME_BUF_STATS_EN
    logic [15:0] repeat_total_q, skip_total_q, err_total_q;
    logic [15:0] skip_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Frames jumped over by a latest-mode swap: all queued but the newest.
    always_comb begin
        skip_inc = '0;
        if (LATEST_ONLY && rd_take) begin
            skip_inc = 16'(ready_cnt_q) - 16'd1;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repeat_total_q <= '0;
            skip_total_q   <= '0;
            err_total_q    <= '0;
        end else begin
            repeat_total_q <= sat_add(repeat_total_q, {15'd0, rd_repeat_d});
            skip_total_q   <= sat_add(skip_total_q, skip_inc);
            err_total_q    <= sat_add(err_total_q, {15'd0, wr_err_d});
        end
    end

    assign repeat_total = repeat_total_q;
    assign skip_total   = skip_total_q;
    assign err_total    = err_total_q;
`endif

endmodule

// File: tb/tb_frame_buf_ring_sel.sv
// Scoreboard bench for frame_buf_ring_sel: DUT A is N=3 FIFO, DUT B is N=4
// latest-only. Stimulus pushes hand-computed expected states; a monitor pops
// and compares after each clock edge. Stats checks build with FRAME_BUF_STATS_EN.
module tb_frame_buf_ring_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_wd, a_rs, b_wd, b_rs;
    logic [1:0] a_rd, a_wr, a_cnt, b_rd, b_wr, b_cnt;
    logic       a_wrdy, a_rep, a_err, b_wrdy, b_rep, b_err;
`ifdef FRAME_BUF_STATS_EN
    logic [15:0] a_rpt, a_skp, a_ert, b_rpt, b_skp, b_ert;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_buf_ring_sel #(.NUM_BUFS(3), .LATEST_ONLY(1'b0)) u_a (
        .clk(clk), .rst(rst), .wr_done(a_wd), .rd_swap(a_rs),
        .wr_idx(a_wr), .rd_idx(a_rd), .wr_ready(a_wrdy), .ready_cnt(a_cnt),
        .rd_repeat(a_rep), .wr_err(a_err)
`ifdef FRAME_BUF_STATS_EN
        , .repeat_total(a_rpt), .skip_total(a_skp), .err_total(a_ert)
`endif
    );

    frame_buf_ring_sel #(.NUM_BUFS(4), .LATEST_ONLY(1'b1)) u_b (
        .clk(clk), .rst(rst), .wr_done(b_wd), .rd_swap(b_rs),
        .wr_idx(b_wr), .rd_idx(b_rd), .wr_ready(b_wrdy), .ready_cnt(b_cnt),
        .rd_repeat(b_rep), .wr_err(b_err)
`ifdef FRAME_BUF_STATS_EN
        , .repeat_total(b_rpt), .skip_total(b_skp), .err_total(b_ert)
`endif
    );

    typedef struct {
        bit         dut;
        logic [1:0] rd, wr, cnt;
        logic       wrdy, rep, err;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(input bit dut, input int rd, input int wr, input int cnt,
                                input logic wrdy, input logic rep, input logic err,
                                input string name);
        exp_t e;
        e.dut = dut; e.rd = 2'(rd); e.wr = 2'(wr); e.cnt = 2'(cnt);
        e.wrdy = wrdy; e.rep = rep; e.err = err; e.name = name;
        return e;
    endfunction

    task automatic check_state(input exp_t e);
        logic [1:0] rd, wr, cnt;
        logic       wrdy, rep, err;
        if (e.dut) begin
            rd = b_rd; wr = b_wr; cnt = b_cnt; wrdy = b_wrdy; rep = b_rep; err = b_err;
        end else begin
            rd = a_rd; wr = a_wr; cnt = a_cnt; wrdy = a_wrdy; rep = a_rep; err = a_err;
        end
        checks++;
        if ({rd, wr, cnt, wrdy, rep, err} !== {e.rd, e.wr, e.cnt, e.wrdy, e.rep, e.err}) begin
            errors++;
            $display("FAIL %s: got rd=%0d wr=%0d cnt=%0d rdy=%0b rep=%0b err=%0b, want rd=%0d wr=%0d cnt=%0d rdy=%0b rep=%0b err=%0b",
                     e.name, rd, wr, cnt, wrdy, rep, err,
                     e.rd, e.wr, e.cnt, e.wrdy, e.rep, e.err);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // One-cycle stimulus on the DUT named in e; expected post-edge state queued.
    task automatic op(input logic wd, input logic rs, input exp_t e);
        @(negedge clk);
        a_wd = e.dut ? 1'b0 : wd;
        a_rs = e.dut ? 1'b0 : rs;
        b_wd = e.dut ? wd : 1'b0;
        b_rs = e.dut ? rs : 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        a_wd = 1'b0; a_rs = 1'b0; b_wd = 1'b0; b_rs = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses never observed", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: the DUT presents a new state after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_state(e);
            end
        end
    end

    // Ring invariant on both instances every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (int'(a_wr) != (int'(a_rd) + int'(a_cnt) + 1) % 3 || a_wrdy != (a_cnt != 2'd2)
                || a_rd > 2'd2 || a_wr > 2'd2) begin
                errors++;
                $display("FAIL invariant_a: rd=%0d wr=%0d cnt=%0d rdy=%0b", a_rd, a_wr, a_cnt,
                         a_wrdy);
            end
            checks++;
            if (int'(b_wr) != (int'(b_rd) + int'(b_cnt) + 1) % 4 || b_wrdy != (b_cnt != 2'd3))
            begin
                errors++;
                $display("FAIL invariant_b: rd=%0d wr=%0d cnt=%0d rdy=%0b", b_rd, b_wr, b_cnt,
                         b_wrdy);
            end
        end
    end

    initial begin
        int rd_seq[7];
        int wr_seq[7];
        rd_seq = '{1, 2, 0, 1, 2, 0, 1};
        wr_seq = '{2, 0, 1, 2, 0, 1, 2};
        rst = 1'b1;
        a_wd = 1'b0; a_rs = 1'b0; b_wd = 1'b0; b_rs = 1'b0;
        #12;
        check_state(mk(0, 0, 1, 0, 1, 0, 0, "reset_a"));
        check_state(mk(1, 0, 1, 0, 1, 0, 0, "reset_b"));
        @(negedge clk);
        rst = 1'b0;

        // Fill, overflow, swap, then empty-swap and simultaneous events.
        op(1, 0, mk(0, 0, 2, 1, 1, 0, 0, "t2_wr1"));
        op(1, 0, mk(0, 0, 0, 2, 0, 0, 0, "t2_wr2_full"));
        op(1, 0, mk(0, 0, 0, 2, 0, 0, 1, "t2_wr_err"));
        op(0, 1, mk(0, 1, 0, 1, 1, 0, 0, "t2_swap"));
        op(0, 1, mk(0, 2, 0, 0, 1, 0, 0, "t3_drain"));
        op(0, 1, mk(0, 2, 0, 0, 1, 1, 0, "t3_repeat"));
        op(1, 1, mk(0, 2, 1, 1, 1, 1, 0, "t3_both_empty"));
        op(1, 0, mk(0, 2, 2, 2, 0, 0, 0, "t3_fill"));
        op(1, 1, mk(0, 0, 2, 1, 1, 0, 1, "t3_both_full"));
        op(1, 1, mk(0, 1, 0, 1, 1, 0, 0, "t3_both_fifo"));
        op(0, 0, mk(0, 1, 0, 1, 1, 0, 0, "t3_idle"));
        drain();

        // Asynchronous reset with a frame queued, checked before any edge.
        #2;
        rst = 1'b1;
        #1;
        check_state(mk(0, 0, 1, 0, 1, 0, 0, "t1_async_reset_a"));
`ifdef FRAME_BUF_STATS_EN
        chk16("t1_err_total_cleared", a_ert, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Latest-only ring of four.
        op(1, 0, mk(1, 0, 2, 1, 1, 0, 0, "t4_wr1"));
        op(1, 0, mk(1, 0, 3, 2, 1, 0, 0, "t4_wr2"));
        op(0, 1, mk(1, 2, 3, 0, 1, 0, 0, "t4_latest_swap"));
        op(0, 0, mk(1, 2, 3, 0, 1, 0, 0, "t4_idle"));
        drain();
`ifdef FRAME_BUF_STATS_EN
        chk16("t4_skip_total", b_skp, 16'd1);
`endif
        op(1, 0, mk(1, 2, 0, 1, 1, 0, 0, "t4_wr3"));
        op(1, 0, mk(1, 2, 1, 2, 1, 0, 0, "t4_wr4"));
        op(1, 0, mk(1, 2, 2, 3, 0, 0, 0, "t4_wr5_full"));
        op(1, 1, mk(1, 1, 2, 0, 1, 0, 1, "t4_both_full"));
        op(1, 1, mk(1, 1, 3, 1, 1, 1, 0, "t4_both_empty"));
        op(1, 1, mk(1, 2, 0, 1, 1, 0, 0, "t4_both_latest"));
        op(0, 0, mk(1, 2, 0, 1, 1, 0, 0, "t4_idle2"));
        drain();
`ifdef FRAME_BUF_STATS_EN
        chk16("t4_skip_total_final", b_skp, 16'd3);
        chk16("t4_err_total", b_ert, 16'd1);
        chk16("t4_repeat_total", b_rpt, 16'd1);
`endif

        // Seven write/swap round trips on the ring of three.
        for (int i = 0; i < 7; i++) begin
            op(1, 0, mk(0, (i == 0) ? 0 : rd_seq[i-1], wr_seq[i], 1, 1, 0, 0, "t5_write"));
            op(0, 1, mk(0, rd_seq[i], wr_seq[i], 0, 1, 0, 0, "t5_swap"));
        end
        op(0, 0, mk(0, 1, 2, 0, 1, 0, 0, "t5_idle"));
        drain();

`ifdef FRAME_BUF_STATS_EN
        // Repeat counter saturation.
        for (int i = 0; i < 70000; i++) begin
            op(0, 1, mk(0, 1, 2, 0, 1, 1, 0, "t6_repeat"));
        end
        op(0, 0, mk(0, 1, 2, 0, 1, 0, 0, "t6_idle"));
        drain();
        chk16("t6_repeat_saturated", a_rpt, 16'hFFFF);
        chk16("t6_fifo_skip_total", a_skp, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
